sram_like_axi_arbiter: RTL and testbench
========================================

// Module: sram_like_axi_arbiter
// PURPOSE
//  Shares one AXI3 master port between the core's uncached inst and data SRAM-like ports.
//  Sits between the mips core and the system AXI crossbar, on the cache-bypass path.
//  Round-robin arbitration; one outstanding single-beat transaction at a time.
//  Converts each request to a single AR/R read or an AW/W/B write, and returns data_ok.
// PARAMETERS
//  INST_ID   4'd0  arid driven for inst reads
//  DATA_ID   4'd1  arid/awid driven for data accesses
//  DATA_WINS 1     tie-break winner after reset: 1 = data, 0 = inst
// PORTS
//  clk                  in   1   clock; all logic is on the rising edge
//  rst                  in   1   synchronous reset, active-high
//  inst_req/inst_wr     in   1   inst request; inst_wr is ignored (reads only)
//  inst_size            in   2   0=byte 1=half 2=word
//  inst_addr            in   32  byte address
//  inst_rdata           out  32  read data, valid while inst_data_ok=1
//  inst_addr_ok         out  1   request accepted this cycle
//  inst_data_ok         out  1   one-cycle completion pulse
//  data_req/data_wr     in   1   data request; data_wr=1 means write
//  data_size/data_addr  in   2/32  as for the inst port
//  data_wdata           in   32  write data, lane-aligned to addr[1:0]
//  data_rdata/data_addr_ok/data_data_ok  out  32/1/1  as for the inst port
//  arid araddr arlen arsize arburst arvalid  out  4/32/4/3/2/1   AR channel
//  arlock arcache arprot                     out  2/4/3          constant 0
//  arready                                   in   1
//  rid rdata rresp rlast rvalid / rready     in 4/32/2/1/1 / out 1  R channel
//  awid awaddr awlen awsize awburst awvalid  out  4/32/4/3/2/1   AW channel
//  awlock awcache awprot                     out  2/4/3          constant 0
//  awready                                   in   1
//  wid wdata wstrb wlast wvalid / wready     out 4/32/4/1/1 / in 1  W channel
//  bid bresp bvalid / bready                 in 4/2/1 / out 1   B channel
// BEHAVIOUR
//  States: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
//  Reset: state=IDLE; all *valid, *ready, *_addr_ok and *_data_ok = 0.
//   rdata regs = 0; last_grant = ~DATA_WINS (inst) when DATA_WINS=1.
//   Reset mid-transaction abandons it silently (the interconnect shares rst).
//  IDLE, grant (combinational):
//   - Only one port requesting: it wins.
//   - Both requesting: the port not granted last time wins.
//   - Winner gets addr_ok=1 in the same cycle; its addr/size/wdata/wr/id are registered.
//   - Next state: read -> RD_ADDR, write -> WR_ADDR. last_grant is updated.
//   - addr_ok is never asserted outside IDLE.
//  RD_ADDR: arvalid=1 with the registered fields; arlen=0, arburst=2'b01, arsize={1'b0,size}.
//   arvalid/araddr hold until arready. On handshake -> RD_DATA.
//  RD_DATA: rready=1. On rvalid & rid==registered id: latch rdata.
//   Next cycle: the owning port's data_ok=1 for exactly one cycle, then IDLE.
//   rresp is ignored; an error still completes. Beats with a mismatched rid are accepted and dropped.
//  WR_ADDR: awvalid and wvalid asserted together; wlast=1; wid=awid.
//   Each valid drops independently after its own handshake. When both are done -> WR_RESP.
//   Simultaneous awready & wready in the first cycle completes both.
//  WR_RESP: bready=1. On bvalid, data_data_ok pulses next cycle, then IDLE. bresp is ignored.
//  wstrb from size/addr[1:0]: byte -> 4'b0001<<addr[1:0]; half -> addr[1]?4'b1100:4'b0011; word -> 4'b1111.
//   size=3 is treated as word.
//  Turnaround: data_ok cycle = IDLE cycle, so a new addr_ok can coincide with a data_ok.
//  Latency with zero-wait slave: read addr_ok->data_ok = 3 cycles; write = 3 cycles.
//  Outputs are registered except *_addr_ok (combinational from req and state).
// STRUCTURE
//  Package cpu_axi_pkg: state enum, AXI_BURST_INCR=2'b01, size encodings, SZ_BYTE/HALF/WORD.
//  Sub-module axi_wstrb_gen: pure combinational (size, addr[1:0]) -> wstrb, reused by the cache adapter.
// TESTING
//  1. inst_req word read @0xBFC00000, slave answers rdata=0x3C08BFAF after 2 waits
//     -> arid=0, arsize=2, inst_data_ok pulse with inst_rdata=0x3C08BFAF.
//  2. data byte write @0x1FAF0003, wdata=0xAB000000
//     -> wstrb=4'b1000, awsize=0, wlast=1, data_data_ok one cycle after bvalid.
//  3. inst and data requesting every cycle for 8 accesses
//     -> grants alternate D,I,D,I...; neither port starves.
//  4. awready delayed 3 cycles with wready immediate
//     -> wvalid drops after 1 cycle, awvalid holds; WR_RESP entered only after both handshakes.
//  5. rst asserted in RD_DATA before rvalid
//     -> next cycle all valids/readys=0, IDLE, no data_ok; the following request completes normally.
//  6. Read with rresp=2'b10 (SLVERR)
//     -> data_ok still pulses once; the arbiter returns to IDLE.

Source files
------------

// File: rtl/cpu_axi_pkg.sv
// Shared types and constants for the core-side AXI bridge logic.
package cpu_axi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 4;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SIZE_W = 2;
  localparam int unsigned LEN_W  = 4;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [SIZE_W-1:0] SZ_BYTE = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_HALF = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_ADDR,
    WR_RESP
  } arb_state_e;

endpackage

// File: rtl/axi_wstrb_gen.sv
// Byte-lane strobe from access size and low address bits; size=3 behaves as word.
module axi_wstrb_gen
  import cpu_axi_pkg::*;
(
  input  logic [SIZE_W-1:0] size_i,
  input  logic [1:0]        addr_lo_i,
  output logic [STRB_W-1:0] wstrb_o
);

  // Lane decode for byte / half / word accesses
  always_comb begin
    wstrb_o = '1;
    case (size_i)
      SZ_BYTE: wstrb_o = STRB_W'(4'b0001 << addr_lo_i);
      SZ_HALF: wstrb_o = addr_lo_i[1] ? STRB_W'(4'b1100) : STRB_W'(4'b0011);
      default: wstrb_o = '1;
    endcase
  end

endmodule

// File: rtl/sram_like_axi_arbiter.sv
// Round-robin bridge from the core's uncached inst/data SRAM-like ports onto one
// AXI3 master; one single-beat transaction in flight at a time.
module sram_like_axi_arbiter
  import cpu_axi_pkg::*;
#(
  parameter logic [ID_W-1:0] INST_ID   = 4'd0,
  parameter logic [ID_W-1:0] DATA_ID   = 4'd1,
  parameter bit              DATA_WINS = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // inst port
  input  logic                inst_req_i,
  input  logic                inst_wr_i,
  input  logic [SIZE_W-1:0]   inst_size_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic [DATA_W-1:0]   inst_rdata_o,
  output logic                inst_addr_ok_o,
  output logic                inst_data_ok_o,
  // data port
  input  logic                data_req_i,
  input  logic                data_wr_i,
  input  logic [SIZE_W-1:0]   data_size_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_addr_ok_o,
  output logic                data_data_ok_o,
  // AR
  output logic [ID_W-1:0]     arid_o,
  output logic [ADDR_W-1:0]   araddr_o,
  output logic [LEN_W-1:0]    arlen_o,
  output logic [2:0]          arsize_o,
  output logic [1:0]          arburst_o,
  output logic [1:0]          arlock_o,
  output logic [3:0]          arcache_o,
  output logic [2:0]          arprot_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  // R
  input  logic [ID_W-1:0]     rid_i,
  input  logic [DATA_W-1:0]   rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rlast_i,
  input  logic                rvalid_i,
  output logic                rready_o,
  // AW
  output logic [ID_W-1:0]     awid_o,
  output logic [ADDR_W-1:0]   awaddr_o,
  output logic [LEN_W-1:0]    awlen_o,
  output logic [2:0]          awsize_o,
  output logic [1:0]          awburst_o,
  output logic [1:0]          awlock_o,
  output logic [3:0]          awcache_o,
  output logic [2:0]          awprot_o,
  output logic                awvalid_o,
  input  logic                awready_i,
  // W
  output logic [ID_W-1:0]     wid_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic [STRB_W-1:0]   wstrb_o,
  output logic                wlast_o,
  output logic                wvalid_o,
  input  logic                wready_i,
  // B
  input  logic [ID_W-1:0]     bid_i,
  input  logic [1:0]          bresp_i,
  input  logic                bvalid_i,
  output logic                bready_o
);

  arb_state_e          state_q, state_d;
  logic                last_data_q, last_data_d;
  logic                owner_data_q, owner_data_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [SIZE_W-1:0]   size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                inst_data_ok_q, inst_data_ok_d;
  logic                data_data_ok_q, data_data_ok_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;

  logic                grant_inst_c;
  logic                grant_data_c;
  logic [STRB_W-1:0]   data_wstrb_c;
  logic                unused_c;

  // Only the data port can write, so strobes are derived from its request directly
  axi_wstrb_gen u_wstrb (
    .size_i    (data_size_i),
    .addr_lo_i (data_addr_i[1:0]),
    .wstrb_o   (data_wstrb_c)
  );

  // Round-robin grant in IDLE: a lone requester wins, a tie goes to the port not served last
  always_comb begin
    grant_data_c = 1'b0;
    grant_inst_c = 1'b0;
    if (state_q == IDLE) begin
      if (data_req_i && (!inst_req_i || !last_data_q)) begin
        grant_data_c = 1'b1;
      end else if (inst_req_i) begin
        grant_inst_c = 1'b1;
      end
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d        = state_q;
    last_data_d    = last_data_q;
    owner_data_d   = owner_data_q;
    id_d           = id_q;
    addr_d         = addr_q;
    size_d         = size_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    arvalid_d      = 1'b0;
    rready_d       = 1'b0;
    awvalid_d      = 1'b0;
    wvalid_d       = 1'b0;
    bready_d       = 1'b0;
    inst_data_ok_d = 1'b0;
    data_data_ok_d = 1'b0;
    inst_rdata_d   = inst_rdata_q;
    data_rdata_d   = data_rdata_q;

    case (state_q)
      IDLE: begin
        if (grant_data_c) begin
          owner_data_d = 1'b1;
          last_data_d  = 1'b1;
          id_d         = DATA_ID;
          addr_d       = data_addr_i;
          size_d       = data_size_i;
          wdata_d      = data_wdata_i;
          wstrb_d      = data_wstrb_c;
          if (data_wr_i) begin
            state_d   = WR_ADDR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_ADDR;
            arvalid_d = 1'b1;
          end
        end else if (grant_inst_c) begin
          owner_data_d = 1'b0;
          last_data_d  = 1'b0;
          id_d         = INST_ID;
          addr_d       = inst_addr_i;
          size_d       = inst_size_i;
          state_d      = RD_ADDR;
          arvalid_d    = 1'b1;
        end
      end
      RD_ADDR: begin
        if (arready_i) begin
          state_d  = RD_DATA;
          rready_d = 1'b1;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      RD_DATA: begin
        rready_d = 1'b1;
        // Beats carrying another id are consumed and ignored
        if (rvalid_i && (rid_i == id_q)) begin
          state_d  = IDLE;
          rready_d = 1'b0;
          if (owner_data_q) begin
            data_rdata_d   = rdata_i;
            data_data_ok_d = 1'b1;
          end else begin
            inst_rdata_d   = rdata_i;
            inst_data_ok_d = 1'b1;
          end
        end
      end
      WR_ADDR: begin
        awvalid_d = awvalid_q & ~awready_i;
        wvalid_d  = wvalid_q & ~wready_i;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end
      end
      WR_RESP: begin
        bready_d = 1'b1;
        if (bvalid_i) begin
          state_d        = IDLE;
          bready_d       = 1'b0;
          data_data_ok_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= IDLE;
      last_data_q    <= ~DATA_WINS;
      owner_data_q   <= 1'b0;
      id_q           <= '0;
      addr_q         <= '0;
      size_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
      inst_rdata_q   <= '0;
      data_rdata_q   <= '0;
    end else begin
      state_q        <= state_d;
      last_data_q    <= last_data_d;
      owner_data_q   <= owner_data_d;
      id_q           <= id_d;
      addr_q         <= addr_d;
      size_q         <= size_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      arvalid_q      <= arvalid_d;
      rready_q       <= rready_d;
      awvalid_q      <= awvalid_d;
      wvalid_q       <= wvalid_d;
      bready_q       <= bready_d;
      inst_data_ok_q <= inst_data_ok_d;
      data_data_ok_q <= data_data_ok_d;
      inst_rdata_q   <= inst_rdata_d;
      data_rdata_q   <= data_rdata_d;
    end
  end

  assign inst_addr_ok_o = grant_inst_c;
  assign data_addr_ok_o = grant_data_c;
  assign inst_data_ok_o = inst_data_ok_q;
  assign data_data_ok_o = data_data_ok_q;
  assign inst_rdata_o   = inst_rdata_q;
  assign data_rdata_o   = data_rdata_q;

  assign arid_o    = id_q;
  assign araddr_o  = addr_q;
  assign arlen_o   = '0;
  assign arsize_o  = {1'b0, size_q};
  assign arburst_o = AXI_BURST_INCR;
  assign arlock_o  = '0;
  assign arcache_o = '0;
  assign arprot_o  = '0;
  assign arvalid_o = arvalid_q;
  assign rready_o  = rready_q;

  assign awid_o    = id_q;
  assign awaddr_o  = addr_q;
  assign awlen_o   = '0;
  assign awsize_o  = {1'b0, size_q};
  assign awburst_o = AXI_BURST_INCR;
  assign awlock_o  = '0;
  assign awcache_o = '0;
  assign awprot_o  = '0;
  assign awvalid_o = awvalid_q;

  assign wid_o     = id_q;
  assign wdata_o   = wdata_q;
  assign wstrb_o   = wstrb_q;
  assign wlast_o   = 1'b1;
  assign wvalid_o  = wvalid_q;
  assign bready_o  = bready_q;

  // Inputs with no effect on behaviour: inst writes, response codes, rlast, bid
  assign unused_c = ^{inst_wr_i, rresp_i, rlast_i, bid_i, bresp_i};

endmodule

// File: tb/tb_sram_like_axi_arbiter.sv
// Scoreboard bench for sram_like_axi_arbiter with a reactive single-beat AXI slave.
module tb_sram_like_axi_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  sram_like_axi_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .inst_req_i(inst_req), .inst_wr_i(inst_wr), .inst_size_i(inst_size), .inst_addr_i(inst_addr),
    .inst_rdata_o(inst_rdata), .inst_addr_ok_o(inst_addr_ok), .inst_data_ok_o(inst_data_ok),
    .data_req_i(data_req), .data_wr_i(data_wr), .data_size_i(data_size), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_addr_ok_o(data_addr_ok),
    .data_data_ok_o(data_data_ok),
    .arid_o(arid), .araddr_o(araddr), .arlen_o(arlen), .arsize_o(arsize), .arburst_o(arburst),
    .arlock_o(arlock), .arcache_o(arcache), .arprot_o(arprot), .arvalid_o(arvalid), .arready_i(arready),
    .rid_i(rid), .rdata_i(rdata), .rresp_i(rresp), .rlast_i(rlast), .rvalid_i(rvalid), .rready_o(rready),
    .awid_o(awid), .awaddr_o(awaddr), .awlen_o(awlen), .awsize_o(awsize), .awburst_o(awburst),
    .awlock_o(awlock), .awcache_o(awcache), .awprot_o(awprot), .awvalid_o(awvalid), .awready_i(awready),
    .wid_o(wid), .wdata_o(wdata), .wstrb_o(wstrb), .wlast_o(wlast), .wvalid_o(wvalid), .wready_i(wready),
    .bid_i(bid), .bresp_i(bresp), .bvalid_i(bvalid), .bready_o(bready)
  );

  typedef struct {
    bit          is_data;
    bit          wr;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } resp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } chan_t;

  resp_t exp_resp[$];
  chan_t exp_ar[$];
  chan_t exp_aw[$];
  bit    exp_grant[$];
  bit    grant_chk_en = 1'b0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // slave configuration
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  logic [1:0]  rresp_cfg = 2'b00;
  bit          bad_rid_cfg = 1'b0;
  bit          rdata_fixed_en = 1'b0;
  logic [31:0] rdata_fixed = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"}, 32'({arvalid, rready, awvalid, wvalid, bready,
                             inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}), 32'h0);
  endtask

  // Caller is at posedge+#1; returns at posedge+#1 of the cycle after acceptance
  task automatic inst_read(input logic [31:0] addr, input logic [1:0] size, input int lat);
    resp_t r;
    chan_t c;
    int n;
    inst_req = 1'b1; inst_wr = 1'b0; inst_addr = addr; inst_size = size;
    n = 0;
    do begin @(negedge clk); n++; end while (!inst_addr_ok && n < 300);
    if (!inst_addr_ok) chk("inst_accept_timeout", 32'(n), 32'h0);
    else begin
      r.is_data = 1'b0; r.wr = 1'b0; r.lat = lat; r.acc = cyc;
      r.rdata = rdata_fixed_en ? rdata_fixed : ~addr;
      exp_resp.push_back(r);
      c.addr = addr; c.id = 4'd0; c.size = {1'b0, size}; c.wdata = '0; c.strb = '0;
      exp_ar.push_back(c);
    end
    @(posedge clk); #1;
    inst_req = 1'b0;
  endtask

  task automatic data_access(input bit wr, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wd, input logic [3:0] strb, input int lat);
    resp_t r;
    chan_t c;
    int n;
    data_req = 1'b1; data_wr = wr; data_addr = addr; data_size = size; data_wdata = wd;
    n = 0;
    do begin @(negedge clk); n++; end while (!data_addr_ok && n < 300);
    if (!data_addr_ok) chk("data_accept_timeout", 32'(n), 32'h0);
    else begin
      r.is_data = 1'b1; r.wr = wr; r.lat = lat; r.acc = cyc;
      r.rdata = rdata_fixed_en ? rdata_fixed : ~addr;
      exp_resp.push_back(r);
      c.addr = addr; c.id = 4'd1; c.size = {1'b0, size}; c.wdata = wd; c.strb = strb;
      if (wr) exp_aw.push_back(c);
      else    exp_ar.push_back(c);
    end
    @(posedge clk); #1;
    data_req = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (exp_resp.size() != 0 && n < 300) begin @(negedge clk); n++; end
    chk("drain_left", 32'(exp_resp.size()), 32'h0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inst_req = 1'b0; data_req = 1'b0;
    exp_resp.delete(); exp_ar.delete(); exp_aw.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Response monitor: every data_ok must match the oldest accepted request
  initial begin
    resp_t r;
    bit g;
    forever begin
      @(negedge clk);
      if (inst_addr_ok && data_addr_ok) chk("dual_addr_ok", 32'h1, 32'h0);
      if (grant_chk_en && (inst_addr_ok || data_addr_ok)) begin
        if (exp_grant.size() == 0) chk("extra_grant", 32'(data_addr_ok), 32'h2);
        else begin
          g = exp_grant.pop_front();
          chk("grant_order", 32'(data_addr_ok), 32'(g));
        end
      end
      if (inst_data_ok || data_data_ok) begin
        if (exp_resp.size() == 0) begin
          chk("unexpected_data_ok", 32'({inst_data_ok, data_data_ok}), 32'h0);
        end else begin
          r = exp_resp.pop_front();
          chk("data_ok_is_data", 32'(data_data_ok), 32'(r.is_data));
          chk("data_ok_is_inst", 32'(inst_data_ok), 32'(!r.is_data));
          if (!r.wr) chk("rdata", r.is_data ? data_rdata : inst_rdata, r.rdata);
          if (r.lat > 0) chk("latency", 32'(cyc - r.acc), 32'(r.lat));
        end
      end
    end
  end

  // Reactive AXI slave; decisions at negedge take effect at the next posedge
  initial begin
    chan_t c;
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    bit r_pend, aw_seen, w_seen, b_pend, bad_sent;
    logic [3:0] r_id;
    logic [31:0] r_addr;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    r_pend = 0; aw_seen = 0; w_seen = 0; b_pend = 0; bad_sent = 0;
    r_id = '0; r_addr = '0;
    arready = 0; rvalid = 0; rid = 0; rdata = 0; rresp = 0; rlast = 0;
    awready = 0; wready = 0; bvalid = 0; bid = 0; bresp = 0;
    forever begin
      @(negedge clk);
      arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
      if (rst) begin
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        r_pend = 0; aw_seen = 0; w_seen = 0; b_pend = 0; bad_sent = 0;
      end else begin
        if (arvalid && !r_pend) begin
          if (ar_cnt >= ar_wait) begin
            arready = 1; ar_cnt = 0; r_pend = 1; r_cnt = 0; r_id = arid; r_addr = araddr;
            if (exp_ar.size() == 0) chk("unexpected_ar", araddr, 32'hFFFF_FFFF);
            else begin
              c = exp_ar.pop_front();
              chk("araddr", araddr, c.addr);
              chk("arid", 32'(arid), 32'(c.id));
              chk("arsize", 32'(arsize), 32'(c.size));
              chk("ar_len_burst", 32'({arlen, arburst}), 32'h1);
              chk("ar_attr", 32'({arlock, arcache, arprot}), 32'h0);
            end
          end else ar_cnt++;
        end
        if (r_pend && rready) begin
          if (r_cnt >= r_wait) begin
            rvalid = 1; rlast = 1; rresp = rresp_cfg; r_cnt = 0;
            if (bad_rid_cfg && !bad_sent) begin
              rid = r_id ^ 4'h1; rdata = 32'hDEAD_BEEF; bad_sent = 1;
            end else begin
              rid = r_id; rdata = rdata_fixed_en ? rdata_fixed : ~r_addr;
              r_pend = 0; bad_sent = 0;
            end
          end else r_cnt++;
        end
        if (awvalid && !aw_seen) begin
          if (aw_cnt >= aw_wait) begin
            awready = 1; aw_cnt = 0; aw_seen = 1;
            if (exp_aw.size() == 0) chk("unexpected_aw", awaddr, 32'hFFFF_FFFF);
            else begin
              chk("awaddr", awaddr, exp_aw[0].addr);
              chk("awid", 32'(awid), 32'(exp_aw[0].id));
              chk("awsize", 32'(awsize), 32'(exp_aw[0].size));
              chk("aw_len_burst", 32'({awlen, awburst}), 32'h1);
              chk("aw_attr", 32'({awlock, awcache, awprot}), 32'h0);
            end
          end else aw_cnt++;
        end
        if (wvalid && !w_seen) begin
          if (w_cnt >= w_wait) begin
            wready = 1; w_cnt = 0; w_seen = 1;
            if (exp_aw.size() == 0) chk("unexpected_w", wdata, 32'hFFFF_FFFF);
            else begin
              chk("wdata", wdata, exp_aw[0].wdata);
              chk("wstrb", 32'(wstrb), 32'(exp_aw[0].strb));
              chk("wlast_wid", 32'({wlast, wid}), 32'({1'b1, exp_aw[0].id}));
            end
          end else w_cnt++;
        end
        if (aw_seen && w_seen) begin
          aw_seen = 0; w_seen = 0; b_pend = 1; b_cnt = 0;
          if (exp_aw.size() != 0) c = exp_aw.pop_front();
        end
        if (b_pend && bready) begin
          if (b_cnt >= b_wait) begin
            bvalid = 1; bid = 4'd1; bresp = 2'b00; b_pend = 0;
          end else b_cnt++;
        end
      end
    end
  end

  // Directed stimulus
  initial begin
    int n;
    int aw_e[5] = '{1, 1, 1, 1, 0};
    int w_e[5]  = '{1, 0, 0, 0, 0};
    int b_e[5]  = '{0, 0, 0, 0, 1};
    rst = 1'b1;
    inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_idle("por");
    chk("por_rdata", inst_rdata | data_rdata, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: inst word read, data after 2 wait cycles
    r_wait = 2; rdata_fixed_en = 1; rdata_fixed = 32'h3C08_BFAF;
    inst_read(32'hBFC0_0000, 2'd2, 5);
    wait_done();
    r_wait = 0; rdata_fixed_en = 0;

    // 2: data byte write to the top lane
    data_access(1'b1, 2'd0, 32'h1FAF_0003, 32'hAB00_0000, 4'b1000, 3);
    wait_done();

    // 3: both ports saturating; data wins first after reset, then strict alternation
    do_reset();
    for (int i = 0; i < 8; i++) exp_grant.push_back(bit'((i % 2) == 0));
    grant_chk_en = 1'b1;
    fork
      begin
        inst_read(32'hBFC0_0000, 2'd2, 3);
        inst_read(32'hBFC0_0004, 2'd2, 3);
        inst_read(32'hBFC0_0008, 2'd2, 3);
        inst_read(32'hBFC0_000C, 2'd2, 3);
      end
      begin
        data_access(1'b1, 2'd2, 32'h0000_0100, 32'h1122_3344, 4'b1111, 3);
        data_access(1'b0, 2'd1, 32'h0000_0202, 32'h0,         4'b0000, 3);
        data_access(1'b1, 2'd1, 32'h0000_0306, 32'h5566_0000, 4'b1100, 3);
        data_access(1'b0, 2'd0, 32'h0000_0401, 32'h0,         4'b0000, 3);
      end
    join
    wait_done();
    grant_chk_en = 1'b0;
    chk("grants_left", 32'(exp_grant.size()), 32'h0);

    // 4: AW stalled 3 cycles, W accepted immediately
    aw_wait = 3;
    data_access(1'b1, 2'd1, 32'h0000_0802, 32'hBEEF_0000, 4'b1100, 6);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("t4_awvalid_c%0d", k + 1), 32'(awvalid), 32'(aw_e[k]));
      chk($sformatf("t4_wvalid_c%0d", k + 1), 32'(wvalid), 32'(w_e[k]));
      chk($sformatf("t4_bready_c%0d", k + 1), 32'(bready), 32'(b_e[k]));
    end
    aw_wait = 0;
    @(posedge clk); #1;
    wait_done();

    // 5: reset while waiting for R, then a normal access
    r_wait = 6;
    inst_read(32'h0000_1000, 2'd2, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!rready && n < 20);
    chk("t5_rready_seen", 32'(rready), 32'h1);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_resp.delete(); exp_ar.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle("t5_after_rst");
    r_wait = 0;
    @(posedge clk); #1;
    data_access(1'b0, 2'd2, 32'h0000_0040, 32'h0, 4'b0000, 3);
    wait_done();

    // 6: SLVERR read still completes exactly once
    rresp_cfg = 2'b10;
    inst_read(32'h1FC0_0010, 2'd2, 3);
    wait_done();
    rresp_cfg = 2'b00;

    // 7: a beat with a foreign rid is dropped; the matching beat completes
    bad_rid_cfg = 1'b1;
    data_access(1'b0, 2'd2, 32'h2000_0040, 32'h0, 4'b0000, 4);
    wait_done();
    bad_rid_cfg = 1'b0;

    chk("ar_left", 32'(exp_ar.size()), 32'h0);
    chk("aw_left", 32'(exp_aw.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    total++;
    bad++;
    $display("FAIL watchdog: got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
